fetch_controller: RTL and testbench

Sequencer for the instruction-fetch datapath. Owns the PC, drives a request/ready instruction-memory port, and delivers fetched instructions with their PC+4 to the IF/ID register. It also absorbs downstream stalls through a one-entry skid buffer and redirects fetch on taken branches, draining any in-flight memory access first.

---
 rtl/fetch_controller_if.sv | 22 ++
 rtl/fetch_controller.sv | 127 ++++++++++++
 tb/tb_fetch_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/ready port between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_controller_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches, absorbs
// downstream stalls with a one-entry skid buffer and drains on redirects.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_address,
  input  logic                      stall,
  fetch_controller_if.master        imem,
  output logic [31:0]               instruction,
  output logic [31:0]               pc_value,
  output logic                      if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        xfer;
  logic        consume;
  logic        skid_next;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic [31:0] addr_inc;

  assign xfer     = imem.mem_req && imem.mem_ready;
  assign consume  = if_valid && !stall;
  assign target   = {branch_address[31:2], 2'b00};
  assign pc_inc   = pc + 32'd4;
  assign addr_inc = imem.mem_addr + 32'd4;

  // Skid occupancy after this edge, assuming no redirect: it keeps its entry
  // unless consumed, and catches a transfer that the busy output cannot take.
  assign skid_next = !consume && (skid_valid || (xfer && if_valid));

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; blocking ones would make same-edge reads order-dependent.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem.mem_req  <= 1'b0;
      imem.mem_addr <= RESET_PC;
      instruction   <= 32'd0;
      pc_value      <= 32'd0;
      if_valid      <= 1'b0;
      skid_valid    <= 1'b0;
      skid_instr    <= 32'd0;
      skid_pc       <= 32'd0;
    end else if (branch_taken) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      pc         <= target;
      if (!imem.mem_req || xfer) begin
        state         <= FETCH;
        imem.mem_req  <= 1'b1;
        imem.mem_addr <= target;
      end else begin
        // An accepted request cannot be withdrawn; let it finish, then retarget.
        state <= DRAIN;
      end
    end else begin
      case (state)
        IDLE: begin
          state         <= FETCH;
          imem.mem_req  <= 1'b1;
          imem.mem_addr <= pc;
        end

        FETCH: begin
          if (consume) begin
            if (skid_valid) begin
              instruction <= skid_instr;
              pc_value    <= skid_pc;
              skid_valid  <= 1'b0;
            end else if (xfer) begin
              instruction <= imem.mem_rdata;
              pc_value    <= addr_inc;
            end else begin
              if_valid <= 1'b0;
            end
          end else if (xfer) begin
            if (!if_valid) begin
              instruction <= imem.mem_rdata;
              pc_value    <= addr_inc;
              if_valid    <= 1'b1;
            end else begin
              skid_instr <= imem.mem_rdata;
              skid_pc    <= addr_inc;
              skid_valid <= 1'b1;
            end
          end

          if (xfer) begin
            pc            <= pc_inc;
            imem.mem_req  <= !skid_next;
            imem.mem_addr <= pc_inc;
          end else if (!imem.mem_req && !skid_next) begin
            // Skid drained this edge: resume at the already-advanced pc.
            imem.mem_req  <= 1'b1;
            imem.mem_addr <= pc;
          end
        end

        DRAIN: begin
          if (xfer) begin
            state         <= FETCH;
            imem.mem_addr <= pc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: memory returns {16'hC0DE, addr[15:0]}
// so every expected instruction word is written down directly.
module tb_fetch_controller;

  logic        clock;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc_value;
  logic        if_valid;

  int total = 0;
  int bad   = 0;

  fetch_controller_if imem ();

  assign imem.mem_rdata = {16'hC0DE, imem.mem_addr[15:0]};

  fetch_controller #(.RESET_PC(32'h100)) dut (
    .clock          (clock),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .stall          (stall),
    .imem           (imem),
    .instruction    (instruction),
    .pc_value       (pc_value),
    .if_valid       (if_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'd0;
    stall          = 1'b0;
    imem.mem_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_req",   {31'd0, imem.mem_req}, 32'd0);
    check("rst_addr",  imem.mem_addr, 32'h100);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pcv",   pc_value, 32'd0);

    // Stream, zero-wait
    reset = 1'b1;
    step();
    check("e1_req",   {31'd0, imem.mem_req}, 32'd1);
    check("e1_addr",  imem.mem_addr, 32'h100);
    check("e1_valid", {31'd0, if_valid}, 32'd0);
    step();
    check("e2_valid", {31'd0, if_valid}, 32'd1);
    check("e2_instr", instruction, 32'hC0DE0100);
    check("e2_pcv",   pc_value, 32'h104);
    check("e2_addr",  imem.mem_addr, 32'h104);
    step();
    check("e3_instr", instruction, 32'hC0DE0104);
    check("e3_pcv",   pc_value, 32'h108);
    check("e3_addr",  imem.mem_addr, 32'h108);
    step();
    check("e4_pcv",   pc_value, 32'h10C);
    check("e4_addr",  imem.mem_addr, 32'h10C);

    // Stall 4 cycles: output holds 0x108 word, skid takes 0x10C, requests stop
    stall = 1'b1;
    step();
    check("st1_req", {31'd0, imem.mem_req}, 32'd0);
    check("st1_pcv", pc_value, 32'h10C);
    step();
    step();
    step();
    check("st4_req",   {31'd0, imem.mem_req}, 32'd0);
    check("st4_pcv",   pc_value, 32'h10C);
    check("st4_instr", instruction, 32'hC0DE0108);
    stall = 1'b0;
    step();
    check("rel1_pcv",   pc_value, 32'h110);
    check("rel1_instr", instruction, 32'hC0DE010C);
    check("rel1_req",   {31'd0, imem.mem_req}, 32'd1);
    check("rel1_addr",  imem.mem_addr, 32'h110);
    step();
    check("rel2_pcv",   pc_value, 32'h114);
    check("rel2_instr", instruction, 32'hC0DE0110);
    check("rel2_valid", {31'd0, if_valid}, 32'd1);

    // Wait states: ready every third cycle
    imem.mem_ready = 1'b0;
    step();
    check("ws1_valid", {31'd0, if_valid}, 32'd0);
    check("ws1_addr",  imem.mem_addr, 32'h114);
    step();
    check("ws2_addr",  imem.mem_addr, 32'h114);
    check("ws2_req",   {31'd0, imem.mem_req}, 32'd1);
    imem.mem_ready = 1'b1;
    step();
    check("ws3_valid", {31'd0, if_valid}, 32'd1);
    check("ws3_pcv",   pc_value, 32'h118);
    check("ws3_instr", instruction, 32'hC0DE0114);
    imem.mem_ready = 1'b0;
    step();
    check("ws4_valid", {31'd0, if_valid}, 32'd0);
    check("ws4_addr",  imem.mem_addr, 32'h118);
    step();
    imem.mem_ready = 1'b1;
    step();
    check("ws6_pcv",   pc_value, 32'h11C);
    check("ws6_instr", instruction, 32'hC0DE0118);
    check("ws6_addr",  imem.mem_addr, 32'h11C);

    // Branch, zero-wait: in-flight 0x11C data is dropped
    branch_taken   = 1'b1;
    branch_address = 32'h203;
    step();
    branch_taken = 1'b0;
    check("br_addr",  imem.mem_addr, 32'h200);
    check("br_valid", {31'd0, if_valid}, 32'd0);
    check("br_req",   {31'd0, imem.mem_req}, 32'd1);
    step();
    check("br2_valid", {31'd0, if_valid}, 32'd1);
    check("br2_pcv",   pc_value, 32'h204);
    check("br2_instr", instruction, 32'hC0DE0200);

    // Branch during a pending access, retargeted once (latest wins)
    imem.mem_ready = 1'b0;
    step();
    check("bw1_valid", {31'd0, if_valid}, 32'd0);
    branch_taken   = 1'b1;
    branch_address = 32'h400;
    step();
    check("bw2_addr", imem.mem_addr, 32'h204);
    check("bw2_req",  {31'd0, imem.mem_req}, 32'd1);
    branch_address = 32'h500;
    step();
    branch_taken = 1'b0;
    check("bw3_addr", imem.mem_addr, 32'h204);
    imem.mem_ready = 1'b1;
    step();
    check("bw4_addr",  imem.mem_addr, 32'h500);
    check("bw4_valid", {31'd0, if_valid}, 32'd0);
    step();
    check("bw5_pcv",   pc_value, 32'h504);
    check("bw5_instr", instruction, 32'hC0DE0500);

    // Async reset mid-stall with the skid full
    stall = 1'b1;
    step();
    check("rs_req", {31'd0, imem.mem_req}, 32'd0);
    step();
    #2;
    reset = 1'b0;
    #1;
    check("ar_req",   {31'd0, imem.mem_req}, 32'd0);
    check("ar_addr",  imem.mem_addr, 32'h100);
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_instr", instruction, 32'd0);
    check("ar_pcv",   pc_value, 32'd0);
    reset = 1'b1;
    stall = 1'b0;
    step();
    check("rr1_addr", imem.mem_addr, 32'h100);
    check("rr1_req",  {31'd0, imem.mem_req}, 32'd1);
    step();
    check("rr2_pcv",   pc_value, 32'h104);
    check("rr2_valid", {31'd0, if_valid}, 32'd1);
    step();
    check("rr3_pcv",   pc_value, 32'h108);
    check("rr3_instr", instruction, 32'hC0DE0104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
